// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: fixed pipeline priority with a starvation-forced grant for the long-latency unit.
// Optional performance counters are built when WBARB_PERF_EN is defined.
module wb_port_arbiter #(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            p_we,
    input  logic [4:0]      p_waddr,
    input  logic [XLEN-1:0] p_wdata,
    output logic            p_stall,
    input  logic            m_valid,
    input  logic [4:0]      m_waddr,
    input  logic [XLEN-1:0] m_wdata,
    output logic            m_ready,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata
`ifdef WBARB_PERF_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_m_wr_cnt
`endif
);

    typedef enum logic {
        ARB_P,
        ARB_M
    } arb_state_e;

    localparam logic [4:0] LIMIT = 5'(STARVE_LIMIT);

    arb_state_e      state_q, state_d;
    logic [3:0]      wait_cnt_q, wait_cnt_d;
    logic            rf_we_q;
    logic [4:0]      rf_waddr_q;
    logic [XLEN-1:0] rf_wdata_q;

    logic            p_req, m_req;
    logic            grant_p, grant_m;
    logic            p_stall_c, m_ready_c;
    logic [4:0]      cnt_inc;

    assign p_req   = p_we & (p_waddr != 5'd0);
    assign m_req   = m_valid & (m_waddr != 5'd0);
    assign cnt_inc = {1'b0, wait_cnt_q} + 5'd1;

    always_comb begin
        grant_p    = 1'b0;
        grant_m    = 1'b0;
        p_stall_c  = 1'b0;
        m_ready_c  = 1'b0;
        state_d    = ARB_P;
        wait_cnt_d = wait_cnt_q;

        if (state_q == ARB_M && m_req) begin
            grant_m   = 1'b1;
            m_ready_c = 1'b1;
            p_stall_c = p_req;
        end else if (p_req) begin
            grant_p   = 1'b1;
            m_ready_c = m_valid & (m_waddr == 5'd0);
        end else if (m_req) begin
            grant_m   = 1'b1;
            m_ready_c = 1'b1;
        end else begin
            m_ready_c = m_valid;
        end

        // Any pending m that was not accepted is a real (non-x0) request losing to p.
        if (!m_valid || m_ready_c) begin
            wait_cnt_d = '0;
        end else begin
            wait_cnt_d = (cnt_inc >= LIMIT) ? LIMIT[3:0] : cnt_inc[3:0];
            if (state_q == ARB_P && cnt_inc >= LIMIT) begin
                state_d = ARB_M;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ARB_P;
            wait_cnt_q <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rf_we_q    <= grant_p | grant_m;
            if (grant_m) begin
                rf_waddr_q <= m_waddr;
                rf_wdata_q <= m_wdata;
            end else if (grant_p) begin
                rf_waddr_q <= p_waddr;
                rf_wdata_q <= p_wdata;
            end
        end
    end

    // Handshakes are gated so nothing is accepted or stalled while reset is held.
    assign p_stall  = p_stall_c & reset_n;
    assign m_ready  = m_ready_c & reset_n;
    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

`ifdef WBARB_PERF_EN
    logic [31:0] perf_stall_q, perf_m_wr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_q <= '0;
            perf_m_wr_q  <= '0;
        end else begin
            if (p_stall_c) perf_stall_q <= perf_stall_q + 32'd1;
            if (grant_m)   perf_m_wr_q  <= perf_m_wr_q + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_m_wr_cnt  = perf_m_wr_q;
`endif

endmodule
